// File: rtl/decoder_arbiter_if.sv
// Handshake bundle between the requesters and the round-robin decoder arbiter.
// The master side drives the requests; the slave side (the arbiter) drives the decoder lines.
interface decoder_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic       address0;
  logic       address1;
  logic       enable;
  logic [3:0] grant;
  logic       busy;
  logic       timeout;

  modport master (
    output req, done,
    input  address0, address1, enable, grant, busy, timeout
  );

  modport slave (
    input  req, done,
    output address0, address1, enable, grant, busy, timeout
  );
endinterface

// File: rtl/decoder_arbiter.sv
// Round-robin arbiter sharing a 2-to-4 decoder among four requesters.
// Define ARB_TIMEOUT_EN to add a hold watchdog that revokes a grant after TIMEOUT cycles.
module decoder_arbiter #(
  parameter int TIMEOUT = 16
) (
  input logic          clk,
  input logic          reset,
  decoder_arbiter_if.slave bus
);
  // state | meaning
  // IDLE  | no owner; next request found from ptr wins
  // GRANT | owner holds the decoder until done, withdrawal or watchdog
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [1:0] owner, owner_nxt;
  logic [1:0] pick, cand;
  logic       hit;
  logic       release_c;
  logic       expire;

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("decoder_arbiter: TIMEOUT must be >= 2");
  end

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    pick = ptr;
    cand = ptr;
    hit  = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (bus.req[cand]) begin
        pick = cand;
        hit  = 1'b1;
      end
    end
  end

  assign release_c = bus.done | ~bus.req[owner];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 2'd0;
      owner <= 2'd0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    case (state)
      IDLE: begin
        if (hit) begin
          owner_nxt = pick;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (release_c || expire) begin
          state_nxt = IDLE;
          ptr_nxt   = owner + 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt, cnt_nxt;
  logic          tmo_q;

  // A coincident done/withdrawal takes priority, so the pulse only marks forced revocation.
  assign expire = (state == GRANT) && !release_c && (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_nxt = cnt;
    if (state == IDLE) cnt_nxt = '0;
    else               cnt_nxt = cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      tmo_q <= expire;
    end
  end

  assign bus.timeout = tmo_q;
`else
  assign expire      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.enable   = (state == GRANT);
  assign bus.busy     = (state == GRANT);
  assign bus.address0 = owner[0];
  assign bus.address1 = owner[1];
  assign bus.grant    = (state == GRANT) ? (4'b0001 << owner) : 4'b0000;
endmodule

// File: tb/tb_decoder_arbiter.sv
// Self-checking bench for decoder_arbiter: behavioural model plus directed literal checks.
// Build with ARB_TIMEOUT_EN defined to exercise the watchdog.
module tb_decoder_arbiter;
  localparam int TP = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  decoder_arbiter_if bif ();

  decoder_arbiter #(.TIMEOUT(TP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: who owns the decoder, where the search starts, how long the grant has been visible.
  bit         m_busy  = 1'b0;
  bit         m_tmo   = 1'b0;
  int         m_owner = 0;
  int         m_ptr   = 0;
  int         m_held  = 0;
  logic [3:0] m_r;
  bit         m_d;
  logic [3:0] m_grant;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy  = 1'b0;
      m_tmo   = 1'b0;
      m_owner = 0;
      m_ptr   = 0;
      m_held  = 0;
    end else begin
      m_r   = bif.req;
      m_d   = bif.done;
      m_tmo = 1'b0;
      if (!m_busy) begin
        for (int k = 0; k < 4; k++) begin
          if (m_r[(m_ptr + k) % 4]) begin
            m_owner = (m_ptr + k) % 4;
            m_busy  = 1'b1;
            m_held  = 1;
            break;
          end
        end
      end else if (m_d || !m_r[m_owner]) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % 4;
      end else if (TMO_EN && m_held == TP) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % 4;
        m_tmo  = 1'b1;
      end else begin
        m_held++;
      end
    end
    #1;
    m_grant = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    chk("m_enable",  bif.enable,   m_busy);
    chk("m_busy",    bif.busy,     m_busy);
    chk("m_grant",   bif.grant,    m_grant);
    chk("m_address", {bif.address1, bif.address0}, m_owner);
    chk("m_timeout", bif.timeout,  m_tmo);
  end

  task automatic step(input logic [3:0] r, input logic d);
    @(negedge clk);
    bif.req  = r;
    bif.done = d;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [3:0] rq;
    logic       dn;
    bif.req  = 4'b1111;
    bif.done = 1'b0;
    reset    = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_enable",  bif.enable,  1'b0);
    chk("rst_grant",   bif.grant,   4'b0000);
    chk("rst_timeout", bif.timeout, 1'b0);

    @(negedge clk);
    reset   = 1'b0;
    bif.req = 4'b0000;

    // Round-robin with done one cycle after each grant
    step(4'b1111, 1'b0); chk("first_grant", bif.grant, 4'b0001);
    chk("first_addr", {bif.address1, bif.address0}, 2'b00);
    step(4'b1111, 1'b1); chk("gap0", bif.enable, 1'b0);
    step(4'b1111, 1'b0); chk("rr1", bif.grant, 4'b0010);
    step(4'b1111, 1'b1); chk("gap1", bif.enable, 1'b0);
    step(4'b1111, 1'b0); chk("rr2", bif.grant, 4'b0100);
    step(4'b1111, 1'b1); chk("gap2", bif.enable, 1'b0);
    step(4'b1111, 1'b0); chk("rr3", bif.grant, 4'b1000);
    chk("rr3_addr", {bif.address1, bif.address0}, 2'b11);
    step(4'b1111, 1'b1); chk("gap3", bif.enable, 1'b0);
    step(4'b1111, 1'b0); chk("rr4", bif.grant, 4'b0001);
    step(4'b1111, 1'b1);

    // Wrap and skip: owner 2 releases, only 0 and 1 requesting
    step(4'b0100, 1'b0); chk("own2", bif.grant, 4'b0100);
    step(4'b0100, 1'b1);
    step(4'b0011, 1'b0); chk("wrap", bif.grant, 4'b0001);
    step(4'b0011, 1'b1);

    // Withdrawal by owner 1 moves ptr to 2
    step(4'b0010, 1'b0); chk("own1", bif.grant, 4'b0010);
    step(4'b0000, 1'b0); chk("withdraw", bif.enable, 1'b0);
    step(4'b1111, 1'b0); chk("ptr2", bif.grant, 4'b0100);

    // Asynchronous reset between clock edges
    #2;
    reset = 1'b1;
    #1;
    chk("async_grant",  bif.grant,  4'b0000);
    chk("async_enable", bif.enable, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    bif.req  = 4'b0000;
    bif.done = 1'b0;

`ifdef ARB_TIMEOUT_EN
    step(4'b1000, 1'b0); chk("tmo_c1", bif.grant, 4'b1000);
    for (int c = 2; c <= TP; c++) begin
      step(4'b1000, 1'b0); chk("tmo_hold", bif.grant, 4'b1000);
    end
    step(4'b1000, 1'b0);
    chk("tmo_pulse", bif.timeout, 1'b1);
    chk("tmo_enable", bif.enable, 1'b0);
    step(4'b1000, 1'b0);
    chk("tmo_clear", bif.timeout, 1'b0);
    chk("tmo_regrant", bif.grant, 4'b1000);
    for (int c = 2; c <= TP; c++) step(4'b1000, 1'b0);
    step(4'b1000, 1'b1);
    chk("tmo_done_pulse", bif.timeout, 1'b0);
    chk("tmo_done_enable", bif.enable, 1'b0);
`else
    step(4'b1000, 1'b0); chk("hold_c1", bif.grant, 4'b1000);
    for (int c = 0; c < 3 * TP; c++) begin
      step(4'b1000, 1'b0);
      chk("hold_long", bif.grant, 4'b1000);
      chk("hold_notmo", bif.timeout, 1'b0);
    end
    step(4'b1000, 1'b1);
    chk("hold_release", bif.enable, 1'b0);
`endif

    // Randomized phase, all checking done by the model
    rq = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        step(rq, 1'b0);
        @(negedge clk);
        reset = 1'b0;
      end
      if ($urandom_range(0, 5) == 0) rq = 4'($urandom_range(0, 15));
      dn = ($urandom_range(0, 7) == 0);
      step(rq, dn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decoder_arbiter.md
# decoder_arbiter

Round-robin arbiter that shares the 2-to-4 decoder's output lines among four requesters. It sits directly in front of the decoder and drives its `address0`, `address1` and `enable` inputs. Only one requester owns the decoder at a time. Ownership is held until the owner releases it, optionally bounded by a watchdog timeout.

## Interface

Parameters:
- `TIMEOUT`, default 16: maximum cycles a grant may be held. Legal range ≥ 2. Used only when `ARB_TIMEOUT_EN` is defined.

Ports:
- `clk`  input  1  system clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `req`  input  4  request lines; bit i = requester i.
- `done`  input  1  the current owner releases the grant; sampled only in GRANT.
- `address0`  output  1  decoder address LSB (owner index bit 0).
- `address1`  output  1  decoder address MSB (owner index bit 1).
- `enable`  output  1  decoder enable; high exactly while a grant is held.
- `grant`  output  4  one-hot owner indication, equal to what the decoder produces: `grant[{address1,address0}] = enable`, all other bits 0.
- `busy`  output  1  equals `enable`; for status and debug.
- `timeout`  output  1  one-cycle pulse when a grant is forcibly revoked.

## Operation

- State: 2-state FSM, IDLE and GRANT.
- Registers: 2-bit round-robin pointer `ptr`, 2-bit `owner` (drives `address1`/`address0`), optional hold counter.
- Reset values (asynchronous, immediate on `reset`=1):
  - state = IDLE
  - `ptr` = 0, `owner` = 0
  - `enable` = 0, `busy` = 0, `timeout` = 0
  - `grant` = 4'b0000, `address0` = `address1` = 0
  - counter = 0
- IDLE, any `req` bit high:
  - Select the first set bit searching `ptr`, `ptr`+1, `ptr`+2, `ptr`+3, mod 4 (wraps 3→0).
  - `owner` ← selected index, `enable` ← 1, go to GRANT.
- IDLE, `req` = 0: remain in IDLE; outputs unchanged.
- GRANT, release condition = `done`=1, OR `req[owner]`=0 (requester withdrew):
  - `enable` ← 0, `ptr` ← `owner`+1 mod 4, go to IDLE.
  - `owner` holds its value (the address lines are don't-care to the decoder while `enable`=0).
- GRANT, no release condition: hold `owner` and `enable`. No preemption by other requests.
- Timeout revocation follows the same release path, with `timeout` pulsed high for one cycle.
- `done` is ignored in IDLE.
- The `grant` outputs are decoded only from registers, so they are glitch-free.

## Timing

- Grant latency: `req` sampled high in IDLE at edge N → `enable`/`grant` high after edge N.
- Release latency: `done` sampled high at edge M → `enable` low after edge M.
- At least one IDLE cycle between consecutive grants. The maximum grant rate is one per 2 cycles.
- Simultaneous requests at grant edge: the round-robin order from `ptr` decides.
- A requester whose bit is set at the same edge as a release is not considered until the following edge.
- Reset asserted mid-grant: `enable` and `grant` drop immediately (asynchronous), and fairness history is lost (`ptr` = 0).
- Reset release: the FSM starts in IDLE on the first rising `clk` with `reset`=0.

## Configuration

- Macro `ARB_TIMEOUT_EN`.
- Defined:
  - A hold counter of width clog2(`TIMEOUT`+1) clears on entry to GRANT and increments each GRANT cycle.
  - When the counter reaches `TIMEOUT`-1 with no release condition, the next edge forces release: `enable` ← 0, `ptr` advances, and `timeout` is high for exactly one cycle.
  - A grant therefore lasts at most `TIMEOUT` cycles.
  - If `done` or withdrawal coincides with the timeout edge, it is a normal release and `timeout` stays 0.
- Undefined:
  - No counter is instantiated and `timeout` is tied 0.
  - Grants are held indefinitely until release.

## Test plan

- Reset: `reset`=1 with `req`=4'b1111 → `enable`=0, `grant`=0000, `timeout`=0. After `reset` deasserts, first grant goes to requester 0 (`grant`=0001, `address1`/`address0`=00), one cycle after `req` is sampled.
- Round-robin: hold `req`=1111, pulse `done` one cycle after each grant → grant sequence 0001, 0010, 0100, 1000, 0001 with `enable` low one cycle between each.
- Wrap and skip: owner 2 releases, `req`=0011 → next grant is 0001 (search 3, then wraps to 0).
- Withdrawal: owner 1 granted, drop `req[1]` with `done`=0 → `enable` low after that edge, `ptr`=2.
- Timeout (`ARB_TIMEOUT_EN`, `TIMEOUT`=4): hold `req[3]`=1, `done`=0 → `grant`=1000 for exactly 4 cycles, then `timeout`=1 for 1 cycle and `enable`=0. Repeat with `done`=1 on the 4th cycle → `timeout` stays 0.
- Reset mid-grant: assert `reset` between clock edges while `grant`=0100 → `grant`=0000 and `enable`=0 immediately, with no clock edge required.
